// File: rtl/div_request_arbiter.sv
// div_request_arbiter: two-port round-robin front end for a shared iterative
// divider. Latches one DIV/DIVU/REM/REMU request, sequences the divider
// start/done handshake and returns the quotient or remainder to the requester.
// Optional feature macro DIV_BYPASS_EN: resolve divide-by-zero and signed
// overflow locally without starting the divider.
module div_request_arbiter #(
    parameter int unsigned PARALLELISM = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   req0_valid,
    output logic                   req0_ready,
    input  logic [1:0]             req0_op,
    input  logic [PARALLELISM-1:0] req0_dividend,
    input  logic [PARALLELISM-1:0] req0_divisor,
    output logic                   rsp0_valid,
    input  logic                   rsp0_ready,
    output logic [PARALLELISM-1:0] rsp0_data,
    input  logic                   req1_valid,
    output logic                   req1_ready,
    input  logic [1:0]             req1_op,
    input  logic [PARALLELISM-1:0] req1_dividend,
    input  logic [PARALLELISM-1:0] req1_divisor,
    output logic                   rsp1_valid,
    input  logic                   rsp1_ready,
    output logic [PARALLELISM-1:0] rsp1_data,
    output logic                   div_valid,
    output logic                   div_usigned,
    output logic [PARALLELISM-1:0] div_dividend,
    output logic [PARALLELISM-1:0] div_divisor,
    input  logic [PARALLELISM-1:0] div_quotient,
    input  logic [PARALLELISM-1:0] div_reminder,
    input  logic                   div_res_ready
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t                 state, state_nxt;
    logic                   last_grant, grant_id;
    logic [1:0]             op_r;
    logic [PARALLELISM-1:0] dividend_r, divisor_r, result_r;

    logic                   grant_sel, accept, rsp_ready_sel;
    logic [1:0]             sel_op;
    logic [PARALLELISM-1:0] sel_dividend, sel_divisor;
    logic                   byp_hit;
    logic [PARALLELISM-1:0] byp_result;

    // Round-robin pick: on a tie the port not served last wins
    always_comb begin
        grant_sel    = (req0_valid && req1_valid) ? ~last_grant : req1_valid;
        sel_op       = grant_sel ? req1_op       : req0_op;
        sel_dividend = grant_sel ? req1_dividend : req0_dividend;
        sel_divisor  = grant_sel ? req1_divisor  : req0_divisor;
    end

`ifdef DIV_BYPASS_EN
    localparam logic [PARALLELISM-1:0] MOST_NEG = {1'b1, {(PARALLELISM-1){1'b0}}};

    // Locally resolvable corner cases, RISC-V results
    always_comb begin
        byp_hit    = 1'b0;
        byp_result = '0;
        if (sel_divisor == '0) begin
            byp_hit    = 1'b1;
            byp_result = sel_op[1] ? sel_dividend : '1;
        end else if (!sel_op[0] && sel_dividend == MOST_NEG && sel_divisor == '1) begin
            byp_hit    = 1'b1;
            byp_result = sel_op[1] ? '0 : sel_dividend;
        end
    end
`else
    assign byp_hit    = 1'b0;
    assign byp_result = '0;
`endif

    assign rsp_ready_sel = grant_id ? rsp1_ready : rsp0_ready;

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // FSM next state and handshake outputs
    always_comb begin
        state_nxt  = state;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        rsp0_valid = 1'b0;
        rsp1_valid = 1'b0;
        div_valid  = 1'b0;
        accept     = 1'b0;
        case (state)
            IDLE: begin
                // Ready is gated by rst_n so every output reads 0 while reset is held
                req0_ready = rst_n && req0_valid && !grant_sel;
                req1_ready = rst_n && req1_valid && grant_sel;
                accept     = req0_ready || req1_ready;
                if (accept) state_nxt = byp_hit ? RESP : ISSUE;
            end
            ISSUE: begin
                div_valid = 1'b1;
                state_nxt = WAIT;
            end
            WAIT: begin
                if (div_res_ready) state_nxt = RESP;
            end
            RESP: begin
                rsp0_valid = !grant_id;
                rsp1_valid = grant_id;
                if (rsp_ready_sel) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Request latch, result capture and round-robin history
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_r       <= '0;
            dividend_r <= '0;
            divisor_r  <= '0;
            result_r   <= '0;
            grant_id   <= 1'b0;
            last_grant <= 1'b1;
        end else begin
            if (accept) begin
                op_r       <= sel_op;
                dividend_r <= sel_dividend;
                divisor_r  <= sel_divisor;
                grant_id   <= grant_sel;
                if (byp_hit) result_r <= byp_result;
            end
            if (state == WAIT && div_res_ready)
                result_r <= op_r[1] ? div_reminder : div_quotient;
            if (state == RESP && rsp_ready_sel)
                last_grant <= grant_id;
        end
    end

    assign div_usigned  = op_r[0];
    assign div_dividend = dividend_r;
    assign div_divisor  = divisor_r;
    assign rsp0_data    = result_r;
    assign rsp1_data    = result_r;

endmodule

// File: tb/tb_div_request_arbiter.sv
// Randomized self-checking bench for div_request_arbiter with a behavioural
// divider model. Honours DIV_BYPASS_EN when defined.
module tb_div_request_arbiter;

    localparam int unsigned W = 32;
    localparam logic [W-1:0] MOST_NEG = {1'b1, {(W-1){1'b0}}};
`ifdef DIV_BYPASS_EN
    localparam bit BYP_EN = 1'b1;
`else
    localparam bit BYP_EN = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst_n;
    logic         req0_valid, req0_ready, rsp0_valid, rsp0_ready;
    logic [1:0]   req0_op;
    logic [W-1:0] req0_dividend, req0_divisor, rsp0_data;
    logic         req1_valid, req1_ready, rsp1_valid, rsp1_ready;
    logic [1:0]   req1_op;
    logic [W-1:0] req1_dividend, req1_divisor, rsp1_data;
    logic         div_valid, div_usigned, div_res_ready;
    logic [W-1:0] div_dividend, div_divisor, div_quotient, div_reminder;

    int n_tests = 0;
    int n_fail  = 0;

    div_request_arbiter #(.PARALLELISM(W)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
        .req0_dividend(req0_dividend), .req0_divisor(req0_divisor),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_data(rsp0_data),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
        .req1_dividend(req1_dividend), .req1_divisor(req1_divisor),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_data(rsp1_data),
        .div_valid(div_valid), .div_usigned(div_usigned),
        .div_dividend(div_dividend), .div_divisor(div_divisor),
        .div_quotient(div_quotient), .div_reminder(div_reminder),
        .div_res_ready(div_res_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // RISC-V division semantics: {quotient, remainder}
    function automatic logic [2*W-1:0] ref_qr(input logic usg, input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] q, r;
        if (b == '0) begin
            q = '1; r = a;
        end else if (!usg && a == MOST_NEG && b == '1) begin
            q = a; r = '0;
        end else if (usg) begin
            q = a / b; r = a % b;
        end else begin
            q = W'($signed(a) / $signed(b));
            r = W'($signed(a) % $signed(b));
        end
        return {q, r};
    endfunction

    function automatic logic [W-1:0] ref_result(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        logic [2*W-1:0] qr;
        qr = ref_qr(op[0], a, b);
        return op[1] ? qr[W-1:0] : qr[2*W-1:W];
    endfunction

    function automatic logic exp_bypass(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        return BYP_EN && ((b == '0) || (!op[0] && a == MOST_NEG && b == '1));
    endfunction

    // Divider model: random latency, checks operand stability while busy,
    // and emits stray done pulses while idle.
    logic         busy, res_real, slow;
    int unsigned  lat;
    logic         cap_u;
    logic [W-1:0] cap_a, cap_b;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy <= 1'b0; res_real <= 1'b0; div_res_ready <= 1'b0;
            div_quotient <= '0; div_reminder <= '0; lat <= 0;
        end else begin
            div_res_ready <= 1'b0;
            res_real      <= 1'b0;
            if (busy) begin
                check("div_valid_once", W'(div_valid), '0);
                check("div_dividend_hold", div_dividend, cap_a);
                check("div_divisor_hold", div_divisor, cap_b);
                check("div_usigned_hold", W'(div_usigned), W'(cap_u));
                if (lat == 0) begin
                    busy <= 1'b0; div_res_ready <= 1'b1; res_real <= 1'b1;
                    {div_quotient, div_reminder} <= ref_qr(cap_u, cap_a, cap_b);
                end else begin
                    lat <= lat - 1;
                end
            end else if (div_valid) begin
                busy <= 1'b1; cap_a <= div_dividend; cap_b <= div_divisor; cap_u <= div_usigned;
                lat <= slow ? 10 : $urandom_range(0, 6);
            end else if ($urandom_range(0, 7) == 0) begin
                div_res_ready <= 1'b1;
                div_quotient  <= $urandom;
                div_reminder  <= $urandom;
            end
        end
    end

    logic         pend[2];
    logic [1:0]   p_op[2];
    logic [W-1:0] p_a[2], p_b[2];
    logic         lastg;

    task automatic new_req(input int unsigned p, input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        pend[p] = 1'b1; p_op[p] = op; p_a[p] = a; p_b[p] = b;
    endtask

    task automatic rand_req(input int unsigned p);
        logic [W-1:0] a, b;
        case ($urandom_range(0, 7))
            0:       begin a = $urandom; b = '0; end
            1:       begin a = MOST_NEG; b = '1; end
            2, 3:    begin
                a = $urandom_range(0, 1000); b = $urandom_range(1, 20);
                if ($urandom_range(0, 1) == 1) a = -a;
                if ($urandom_range(0, 1) == 1) b = -b;
            end
            default: begin a = $urandom; b = $urandom >> $urandom_range(0, 31); end
        endcase
        new_req(p, 2'($urandom), a, b);
    endtask

    // Idle ports get garbage payloads; pending ports hold theirs
    task automatic drive();
        for (int p = 0; p < 2; p++) begin
            if (!pend[p]) begin
                p_op[p] = 2'($urandom); p_a[p] = $urandom; p_b[p] = $urandom;
            end
        end
        req0_valid = pend[0]; req0_op = p_op[0]; req0_dividend = p_a[0]; req0_divisor = p_b[0];
        req1_valid = pend[1]; req1_op = p_op[1]; req1_dividend = p_a[1]; req1_divisor = p_b[1];
    endtask

    function automatic logic rsp_v(input int unsigned g);
        return (g == 1) ? rsp1_valid : rsp0_valid;
    endfunction

    function automatic logic [W-1:0] rsp_d(input int unsigned g);
        return (g == 1) ? rsp1_data : rsp0_data;
    endfunction

    task automatic check_all_zero(input string tag);
        check({tag, "_rdy"}, W'({req0_ready, req1_ready}), '0);
        check({tag, "_rspv"}, W'({rsp0_valid, rsp1_valid}), '0);
        check({tag, "_rsp0d"}, rsp0_data, '0);
        check({tag, "_rsp1d"}, rsp1_data, '0);
        check({tag, "_divv"}, W'({div_valid, div_usigned}), '0);
        check({tag, "_divd"}, div_dividend, '0);
        check({tag, "_divs"}, div_divisor, '0);
    endtask

    // One complete operation from the currently pending requests
    task automatic run_txn(output logic [W-1:0] data);
        int unsigned  g, hold;
        logic [W-1:0] exp;
        logic         byp, prev, got;
        data = '0;
        drive();
        #1;
        g = (pend[0] && pend[1]) ? ((lastg == 1'b0) ? 1 : 0) : (pend[1] ? 1 : 0);
        check("rsp_idle", W'({rsp0_valid, rsp1_valid}), '0);
        check("req0_ready", W'(req0_ready), W'(g == 0));
        check("req1_ready", W'(req1_ready), W'(g == 1));
        exp = ref_result(p_op[g], p_a[g], p_b[g]);
        byp = exp_bypass(p_op[g], p_a[g], p_b[g]);
        @(posedge clk); #1;
        pend[g] = 1'b0;
        check("ready_after_hs", W'({req0_ready, req1_ready}), '0);
        if (byp) begin
            check("byp_rsp_lat", W'(rsp_v(g)), 1);
            check("byp_no_div", W'(div_valid), '0);
        end else begin
            check("div_valid_lat", W'(div_valid), 1);
            check("rsp_early", W'({rsp0_valid, rsp1_valid}), '0);
            prev = div_res_ready && res_real;
            got  = 1'b0;
            for (int c = 0; c < 40 && !got; c++) begin
                rsp0_ready = 1'($urandom); rsp1_ready = 1'($urandom);
                drive();
                @(posedge clk); #1;
                if (prev) begin
                    check("rsp_lat", W'(rsp_v(g)), 1);
                    got = 1'b1;
                end else begin
                    check("rsp_wait", W'({rsp0_valid, rsp1_valid}), '0);
                    check("div_valid_wait", W'(div_valid), '0);
                end
                check("ready_wait", W'({req0_ready, req1_ready}), '0);
                prev = div_res_ready && res_real;
            end
            if (!got) check("rsp_timeout", '0, 1);
        end
        hold = $urandom_range(0, 3);
        for (int i = 0; i <= int'(hold); i++) begin
            check("rsp_valid", W'(rsp_v(g)), 1);
            check("rsp_other", W'(rsp_v(1 - g)), '0);
            check("rsp_data", rsp_d(g), exp);
            check("ready_resp", W'({req0_ready, req1_ready}), '0);
            check("div_valid_resp", W'(div_valid), '0);
            data = rsp_d(g);
            if (g == 0) begin rsp0_ready = (i == int'(hold)); rsp1_ready = 1'($urandom); end
            else        begin rsp1_ready = (i == int'(hold)); rsp0_ready = 1'($urandom); end
            drive();
            @(posedge clk); #1;
        end
        rsp0_ready = 1'b0; rsp1_ready = 1'b0;
        check("rsp_drop", W'(rsp_v(g)), '0);
        lastg = g[0];
    endtask

    logic [W-1:0] d;

    initial begin
        rst_n = 1'b0; slow = 1'b0; lastg = 1'b1;
        rsp0_ready = 1'b0; rsp1_ready = 1'b0;
        pend[0] = 1'b0; pend[1] = 1'b0;
        drive();
        repeat (3) @(posedge clk);
        #1 check_all_zero("reset");
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;

        new_req(0, 2'b01, 100, 7);
        run_txn(d);
        check("divu_100_7", d, 14);

        new_req(0, 2'b00, 5, 0);
        run_txn(d);
        check("div_by_zero", d, '1);
        new_req(0, 2'b00, MOST_NEG, '1);
        run_txn(d);
        check("div_overflow", d, MOST_NEG);

        for (int t = 0; t < 300; t++) begin
            for (int p = 0; p < 2; p++)
                if (!pend[p] && $urandom_range(0, 2) != 0) rand_req(p);
            if (!pend[0] && !pend[1]) rand_req($urandom_range(0, 1));
            run_txn(d);
        end

        // Abort an operation mid-divide with an asynchronous reset
        pend[0] = 1'b0; pend[1] = 1'b0;
        slow = 1'b1;
        new_req(0, 2'b01, 1000, 3);
        drive();
        #1 check("mw_ready", W'(req0_ready), 1);
        @(posedge clk); #1;
        pend[0] = 1'b0;
        drive();
        check("mw_div_valid", W'(div_valid), 1);
        @(posedge clk); #1;
        @(posedge clk); #1;
        #2 rst_n = 1'b0;
        #1 check_all_zero("async_rst");
        new_req(0, 2'b10, -7, 2);
        new_req(1, 2'b00, 20, -3);
        drive();
        #1 check("rst_ready", W'({req0_ready, req1_ready}), '0);
        @(negedge clk) rst_n = 1'b1;
        lastg = 1'b1; slow = 1'b0;

        run_txn(d);
        check("tie_p0_rem", d, 32'hFFFF_FFFF);
        run_txn(d);
        check("tie_p1_div", d, 32'hFFFF_FFFA);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
